// File: rtl/smvm_stream_tx.sv
// smvm_stream_tx: buffers one sparse matrix-vector job from valid/ready streams,
// then replays it gap-free on the SMVM val/col/ipv input pins.
// Optional protocol checks are compiled in when SMVM_STREAM_TX_CHECK_EN is defined;
// otherwise err is held at 0 and illegal input only corrupts pin traffic.
module smvm_stream_tx #(
    parameter int unsigned VEC_DEPTH = 128,
    parameter int unsigned NZ_DEPTH  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] rows_in,
    input  logic [7:0]  cols_in,
    input  logic        vec_valid,
    output logic        vec_ready,
    input  logic [7:0]  vec_data,
    input  logic        nz_valid,
    output logic        nz_ready,
    input  logic [7:0]  nz_val,
    input  logic [6:0]  nz_col,
    input  logic        nz_row_end,
    input  logic        nz_last,
    output logic [7:0]  val_out,
    output logic [2:0]  col_out,
    output logic        ipv_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned VA_W  = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1;
    localparam int unsigned NA_W  = (NZ_DEPTH > 1) ? $clog2(NZ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(NZ_DEPTH + 1);
    localparam int unsigned IDX_W = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_VEC,
        S_LOAD_NZ,
        S_TX_ROWS,
        S_TX_COLS,
        S_TX_VEC,
        S_TX_VAL,
        S_TX_IDX,
        S_TX_TERM
    } state_t;

    typedef struct packed {
        logic [7:0] val;
        logic [6:0] col;
        logic       row_end;
    } nz_entry_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_nz_cnt;
    logic [11:0]        r_rows;
    logic [7:0]         r_cols;
    logic [7:0]         r_val;
    logic [2:0]         r_col;
    logic               r_ipv;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_vec_ready;
    logic               r_nz_ready;

    logic [7:0]         r_vec_buf [VEC_DEPTH];
    nz_entry_t          r_nz_buf  [NZ_DEPTH];

    state_t             w_state_nx;
    logic [IDX_W-1:0]   w_idx_nx;
    logic [CNT_W-1:0]   w_nz_cnt_nx;
    logic               w_latch;
    logic               w_vec_we;
    logic               w_nz_we;
    logic               w_err_nx;
    logic               w_done_nx;
    logic [7:0]         w_val_nx;
    logic [2:0]         w_col_nx;
    logic               w_ipv_nx;
    logic [7:0]         w_vec_rd;
    nz_entry_t          w_nz_rd;
    logic               w_start_bad;
    logic               w_nz_bad;

`ifdef SMVM_STREAM_TX_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
    // Header the receiver cannot detect, or a vector length the buffer cannot hold
    assign w_start_bad = (rows_in[11:4] == 8'd0) || (cols_in == 8'd0) ||
                         (32'(cols_in) > VEC_DEPTH);
    // Out-of-range column, or a zero value that the receiver would take as a terminator
    assign w_nz_bad    = ({1'b0, nz_col} >= r_cols) || (nz_val == 8'd0);
`else
    localparam logic CHECK_EN = 1'b0;
    assign w_start_bad = 1'b0;
    assign w_nz_bad    = 1'b0;
`endif

    // Next-state, counter and buffer-write control
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_nz_cnt_nx = r_nz_cnt;
        w_latch     = 1'b0;
        w_vec_we    = 1'b0;
        w_nz_we     = 1'b0;
        w_err_nx    = 1'b0;
        w_done_nx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_start_bad) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_state_nx  = S_LOAD_VEC;
                        w_latch     = 1'b1;
                        w_idx_nx    = '0;
                        w_nz_cnt_nx = '0;
                    end
                end
            end
            S_LOAD_VEC: begin
                if (vec_valid && r_vec_ready) begin
                    w_vec_we = 1'b1;
                    if (r_idx == r_cols - 8'd1) begin
                        w_state_nx = S_LOAD_NZ;
                        w_idx_nx   = '0;
                    end else begin
                        w_idx_nx = r_idx + IDX_W'(1);
                    end
                end
            end
            S_LOAD_NZ: begin
                if (nz_valid && r_nz_ready) begin
                    if (w_nz_bad) begin
                        // Dropped entry; its end-of-job marker still counts
                        w_err_nx = 1'b1;
                        if (nz_last) begin
                            w_state_nx = S_TX_ROWS;
                        end
                    end else begin
                        w_nz_we     = 1'b1;
                        w_nz_cnt_nx = r_nz_cnt + CNT_W'(1);
                        if (nz_last) begin
                            w_state_nx = S_TX_ROWS;
                        end else if (w_nz_cnt_nx == CNT_W'(NZ_DEPTH)) begin
                            // Buffer full with no end marker: abort, or send what we have
                            if (CHECK_EN) begin
                                w_err_nx   = 1'b1;
                                w_state_nx = S_IDLE;
                            end else begin
                                w_state_nx = S_TX_ROWS;
                            end
                        end
                    end
                end
            end
            S_TX_ROWS: begin
                w_state_nx = S_TX_COLS;
            end
            S_TX_COLS: begin
                w_state_nx = S_TX_VEC;
                w_idx_nx   = '0;
            end
            S_TX_VEC: begin
                if (r_idx == r_cols - 8'd1) begin
                    w_idx_nx   = '0;
                    w_state_nx = (r_nz_cnt != '0) ? S_TX_VAL : S_TX_TERM;
                end else begin
                    w_idx_nx = r_idx + IDX_W'(1);
                end
            end
            S_TX_VAL: begin
                w_state_nx = S_TX_IDX;
            end
            S_TX_IDX: begin
                if (r_idx == IDX_W'(r_nz_cnt) - IDX_W'(1)) begin
                    w_state_nx = S_TX_TERM;
                end else begin
                    w_state_nx = S_TX_VAL;
                    w_idx_nx   = r_idx + IDX_W'(1);
                end
            end
            S_TX_TERM: begin
                w_state_nx = S_IDLE;
                w_done_nx  = 1'b1;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Pin values for the upcoming state, so the registered pins line up with it
    always_comb begin
        w_val_nx = '0;
        w_col_nx = '0;
        w_ipv_nx = 1'b0;
        w_vec_rd = r_vec_buf[w_idx_nx[VA_W-1:0]];
        w_nz_rd  = r_nz_buf[w_idx_nx[NA_W-1:0]];
        case (w_state_nx)
            S_TX_ROWS: {w_val_nx, w_ipv_nx, w_col_nx} = r_rows;
            S_TX_COLS: {w_val_nx, w_ipv_nx, w_col_nx} = {4'b0, r_cols};
            S_TX_VEC:  w_val_nx = w_vec_rd;
            S_TX_VAL: begin
                w_val_nx = w_nz_rd.val;
                w_ipv_nx = w_nz_rd.row_end;
            end
            S_TX_IDX:  {w_val_nx, w_ipv_nx, w_col_nx} = {5'b0, w_nz_rd.col};
            default: begin
                w_val_nx = '0;
                w_col_nx = '0;
                w_ipv_nx = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_nz_cnt    <= '0;
            r_rows      <= '0;
            r_cols      <= '0;
            r_val       <= '0;
            r_col       <= '0;
            r_ipv       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_vec_ready <= 1'b0;
            r_nz_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_nz_cnt    <= w_nz_cnt_nx;
            if (w_latch) begin
                r_rows <= rows_in;
                r_cols <= cols_in;
            end
            r_val       <= w_val_nx;
            r_col       <= w_col_nx;
            r_ipv       <= w_ipv_nx;
            r_busy      <= (w_state_nx != S_IDLE);
            r_done      <= w_done_nx;
            r_err       <= w_err_nx;
            r_vec_ready <= (w_state_nx == S_LOAD_VEC);
            r_nz_ready  <= (w_state_nx == S_LOAD_NZ) && (w_nz_cnt_nx < CNT_W'(NZ_DEPTH));
        end
    end

    // Job storage; contents survive reset and are simply overwritten by the next job
    always_ff @(posedge clk) begin
        if (w_vec_we) begin
            r_vec_buf[r_idx[VA_W-1:0]] <= vec_data;
        end
        if (w_nz_we) begin
            r_nz_buf[r_nz_cnt[NA_W-1:0]] <= {nz_val, nz_col, nz_row_end};
        end
    end

    assign vec_ready = r_vec_ready;
    assign nz_ready  = r_nz_ready;
    assign val_out   = r_val;
    assign col_out   = r_col;
    assign ipv_out   = r_ipv;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Self-checking bench for smvm_stream_tx: a scoreboard queue holds the expected
// per-cycle pin traffic of each job and a negedge monitor pops and compares it.
module tb_smvm_stream_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] rows_in;
    logic [7:0]  cols_in;
    logic        vec_valid;
    logic        vec_ready;
    logic [7:0]  vec_data;
    logic        nz_valid;
    logic        nz_ready;
    logic [7:0]  nz_val;
    logic [6:0]  nz_col;
    logic        nz_row_end;
    logic        nz_last;
    logic [7:0]  val_out;
    logic [2:0]  col_out;
    logic        ipv_out;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    smvm_stream_tx #(.VEC_DEPTH(128), .NZ_DEPTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rows_in    (rows_in),
        .cols_in    (cols_in),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_data   (vec_data),
        .nz_valid   (nz_valid),
        .nz_ready   (nz_ready),
        .nz_val     (nz_val),
        .nz_col     (nz_col),
        .nz_row_end (nz_row_end),
        .nz_last    (nz_last),
        .val_out    (val_out),
        .col_out    (col_out),
        .ipv_out    (ipv_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

`ifdef SMVM_STREAM_TX_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic       done;
        logic       busy;
        logic       ipv;
        logic [2:0] col;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    bit   in_tx    = 1'b0;

    // Current job description
    logic [11:0] j_rows;
    logic [7:0]  j_cols;
    logic [7:0]  j_vec  [128];
    logic [7:0]  j_nzv  [64];
    logic [6:0]  j_nzc  [64];
    logic        j_nzre [64];
    bit          j_keep [64];
    int          j_nnz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One transmitted 12-bit field as seen on the pins while busy
    function automatic exp_t fld(input logic [11:0] f);
        exp_t e;
        e.done = 1'b0;
        e.busy = 1'b1;
        e.val  = f[11:4];
        e.ipv  = f[3];
        e.col  = f[2:0];
        return e;
    endfunction

    task automatic push_expected();
        exp_t e;
        exp_q.push_back(fld(j_rows));
        exp_q.push_back(fld({4'b0, j_cols}));
        for (int i = 0; i < int'(j_cols); i++) exp_q.push_back(fld({j_vec[i], 4'b0}));
        for (int i = 0; i < j_nnz; i++) begin
            if (j_keep[i]) begin
                exp_q.push_back(fld({j_nzv[i], j_nzre[i], 3'b000}));
                exp_q.push_back(fld({5'b0, j_nzc[i]}));
            end
        end
        exp_q.push_back(fld(12'h000));
        e      = fld(12'h000);
        e.busy = 1'b0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: pins must be 0 until a transmission starts, then match cycle by cycle
    always @(negedge clk) begin
        exp_t obs;
        exp_t e;
        if (mon_en) begin
            obs.done = done;
            obs.busy = busy;
            obs.ipv  = ipv_out;
            obs.col  = col_out;
            obs.val  = val_out;
            if (!in_tx && exp_q.size() > 0 && (val_out != 8'd0 || col_out != 3'd0 || ipv_out))
                in_tx = 1'b1;
            if (in_tx) begin
                e = exp_q.pop_front();
                check("tx_pins", 32'(obs), 32'(e));
                if (e.done) in_tx = 1'b0;
            end else begin
                check("idle_pins", 32'({ipv_out, col_out, val_out}), 32'd0);
            end
        end
    end

    task automatic vec_beat(input logic [7:0] d);
        bit got;
        got       = 1'b0;
        vec_valid = 1'b1;
        vec_data  = d;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (vec_ready) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        vec_valid = 1'b0;
        if (!got) check("vec_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic nz_beat(input logic [7:0] v, input logic [6:0] c, input logic re, input logic last);
        bit got;
        got        = 1'b0;
        nz_valid   = 1'b1;
        nz_val     = v;
        nz_col     = c;
        nz_row_end = re;
        nz_last    = last;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (nz_ready) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        nz_valid = 1'b0;
        nz_last  = 1'b0;
        if (!got) check("nz_handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive_job(input bit bubble, input bit send_last);
        @(posedge clk);
        #1;
        start   = 1'b1;
        rows_in = j_rows;
        cols_in = j_cols;
        @(posedge clk);
        #1;
        start   = 1'b0;
        rows_in = '0;
        cols_in = '0;
        for (int i = 0; i < int'(j_cols); i++) begin
            vec_beat(j_vec[i]);
            if (bubble) begin
                // A start during the load must be ignored
                if (i == 0) begin
                    start   = 1'b1;
                    rows_in = 12'hFFF;
                    cols_in = 8'd9;
                end
                @(posedge clk);
                #1;
                start   = 1'b0;
                rows_in = '0;
                cols_in = '0;
            end
        end
        for (int i = 0; i < j_nnz; i++) begin
            nz_beat(j_nzv[i], j_nzc[i], j_nzre[i], send_last && (i == j_nnz - 1));
            if (bubble) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        bit drained;
        drained = 1'b0;
        for (int t = 0; t < 2000 && !drained; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !in_tx) drained = 1'b1;
        end
        if (!drained) begin
            check("tx_drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            in_tx = 1'b0;
        end
    endtask

    task automatic run_job(input bit bubble);
        push_expected();
        drive_job(bubble, 1'b1);
        wait_drain();
    endtask

    task automatic set_basic_job();
        j_rows = 12'd20;
        j_cols = 8'd4;
        for (int i = 0; i < 4; i++) j_vec[i] = 8'(i + 1);
        j_nnz     = 2;
        j_nzv[0]  = 8'd5;    j_nzc[0] = 7'd2; j_nzre[0] = 1'b0; j_keep[0] = 1'b1;
        j_nzv[1]  = 8'hFD;   j_nzc[1] = 7'd0; j_nzre[1] = 1'b1; j_keep[1] = 1'b1;
    endtask

    task automatic set_full_job();
        j_rows   = 12'd300;
        j_cols   = 8'd3;
        j_vec[0] = 8'h80;
        j_vec[1] = 8'h7F;
        j_vec[2] = 8'h00;
        j_nnz    = 64;
        for (int i = 0; i < 64; i++) begin
            j_nzv[i]  = 8'(i * 3 + 1);
            j_nzc[i]  = 7'(i % 3);
            j_nzre[i] = ((i % 4) == 3);
            j_keep[i] = 1'b1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        rows_in    = '0;
        cols_in    = '0;
        vec_valid  = 1'b0;
        vec_data   = '0;
        nz_valid   = 1'b0;
        nz_val     = '0;
        nz_col     = '0;
        nz_row_end = 1'b0;
        nz_last    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              32'({vec_ready, nz_ready, err, done, busy, ipv_out, col_out, val_out}), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic job, back-to-back handshakes
        set_basic_job();
        run_job(1'b0);

        // Same job with upstream bubbles: transmit must be identical
        run_job(1'b1);

        // Full nonzero buffer ending exactly on the 64th entry
        set_full_job();
        run_job(1'b0);

        if (CHK) begin
            // Illegal entries are dropped; the last one's end marker still closes the job
            j_rows = 12'd100;
            j_cols = 8'd2;
            j_vec[0] = 8'd3;
            j_vec[1] = 8'd4;
            j_nnz    = 3;
            j_nzv[0] = 8'd7; j_nzc[0] = 7'd1; j_nzre[0] = 1'b1; j_keep[0] = 1'b1;
            j_nzv[1] = 8'd5; j_nzc[1] = 7'd5; j_nzre[1] = 1'b0; j_keep[1] = 1'b0;
            j_nzv[2] = 8'd0; j_nzc[2] = 7'd0; j_nzre[2] = 1'b1; j_keep[2] = 1'b0;
            run_job(1'b0);

            // 64 entries without an end marker: error pulse, back to IDLE, no traffic
            set_full_job();
            drive_job(1'b0, 1'b0);
            @(negedge clk);
            check("overflow_err", 32'({err, busy}), 32'b10);
            @(negedge clk);
            check("overflow_err_pulse", 32'({err, busy, done}), 32'b000);
            repeat (4) @(negedge clk);
        end

        // Start with an undetectable header (rows=10)
        @(posedge clk);
        #1;
        start   = 1'b1;
        rows_in = 12'd10;
        cols_in = 8'd4;
        @(posedge clk);
        #1;
        start   = 1'b0;
        rows_in = '0;
        cols_in = '0;
        @(negedge clk);
        check("bad_rows_err", 32'({err, busy}), CHK ? 32'b10 : 32'b01);
        @(negedge clk);
        check("bad_rows_err_pulse", 32'(err), 32'd0);
        if (!CHK) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end

        // Reset in the second vector cycle of a transmission
        mon_en = 1'b0;
        set_basic_job();
        for (int i = 0; i < 4; i++) j_vec[i] = 8'(10 * (i + 1));
        j_nnz    = 1;
        j_nzv[0] = 8'd9; j_nzc[0] = 7'd1; j_nzre[0] = 1'b1;
        drive_job(1'b0, 1'b1);
        @(negedge clk);
        check("rst_test_rows", 32'({busy, ipv_out, col_out, val_out}), 32'({1'b1, 1'b0, 3'd4, 8'h01}));
        @(negedge clk);
        @(negedge clk);
        check("rst_test_vec0", 32'(val_out), 32'd10);
        @(negedge clk);
        check("rst_test_vec1", 32'(val_out), 32'd20);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_job",
              32'({vec_ready, nz_ready, err, done, busy, ipv_out, col_out, val_out}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'({err, done, busy, ipv_out, col_out, val_out}), 32'd0);
        end
        mon_en = 1'b1;

        // A following job runs normally
        set_basic_job();
        run_job(1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
